// File: rtl/dvi_tmds_encoder.sv
// Three-channel DVI TMDS encoder.
// Each channel first turns expanded 8-bit colour into a transition-minimised
// 9-bit word. It then DC-balances that word into a 10-bit symbol, using a
// running disparity counter kept per channel. During blanking each channel
// emits one of four control symbols, and the disparity counter is cleared.
// Channel 0 (blue) carries {vsync,hsync} in blanking; channels 1 and 2 carry 00.
// Latency is two pixel clocks, with one symbol per channel per clock.
module dvi_tmds_encoder #(
  parameter int BPC = 5
) (
  input  logic           clk_pix,
  input  logic           rst_pix,
  input  logic           de,
  input  logic           hsync,
  input  logic           vsync,
  input  logic [BPC-1:0] r,
  input  logic [BPC-1:0] g,
  input  logic [BPC-1:0] b,
  output logic [9:0]     tmds_ch0,
  output logic [9:0]     tmds_ch1,
  output logic [9:0]     tmds_ch2
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  if (BPC < 4 || BPC > 8) begin : g_bad_bpc
    $error("dvi_tmds_encoder: BPC must be in 4..8");
  end

  // Widen to 8 bits by repeating the MSBs into the vacated LSBs. The guard
  // bit keeps the zero-fill non-empty when BPC is 8.
  function automatic logic [7:0] expand(input logic [BPC-1:0] x);
    logic [16:0] rep;
    rep = {x, x, {(17 - 2 * BPC){1'b0}}};
    return rep[16:9];
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Transition minimisation: pick the XOR or XNOR chain, whichever yields
  // fewer transitions. Bit 8 records which chain was used (1 means XOR).
  function automatic logic [8:0] minimise(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = CTRL_00;
      2'b01:   s = CTRL_01;
      2'b10:   s = CTRL_10;
      default: s = CTRL_11;
    endcase
    return s;
  endfunction

  logic [7:0] d8 [3];
  assign d8[0] = expand(b);
  assign d8[1] = expand(g);
  assign d8[2] = expand(r);

  // ---- stage 1: transition-minimised word, with de/ctrl alongside ----
  logic [8:0] qm_d [3];
  logic [8:0] qm_q [3];
  logic       de_q;
  logic [1:0] ctrl_q;

  // Combinational minimisation of each channel's expanded colour
  always_comb begin
    for (int c = 0; c < 3; c++) qm_d[c] = minimise(d8[c]);
  end

  // Minimised data register; data path carries no reset
  always_ff @(posedge clk_pix) begin
    for (int c = 0; c < 3; c++) qm_q[c] <= qm_d[c];
  end

  // Control register for de and blue-channel sync
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      de_q   <= 1'b0;
      ctrl_q <= 2'b00;
    end else begin
      de_q   <= de;
      ctrl_q <= {vsync, hsync};
    end
  end

  // ---- stage 2: DC balancing and control symbol insertion ----
  logic [9:0]        sym_d [3];
  logic [9:0]        sym_q [3];
  logic signed [4:0] cnt_d [3];
  logic signed [4:0] cnt_q [3];

  // Choose the symbol that pulls running disparity towards zero
  always_comb begin
    logic [3:0]        n1q;
    logic signed [5:0] diff;
    logic signed [5:0] cnt6;
    logic signed [5:0] nxt;
    logic [8:0]        qm;
    for (int c = 0; c < 3; c++) begin
      qm   = qm_q[c];
      n1q  = popcount8(qm[7:0]);
      diff = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
      cnt6 = {cnt_q[c][4], cnt_q[c]};
      nxt  = '0;
      sym_d[c] = ctrl_symbol((c == 0) ? ctrl_q : 2'b00);
      if (de_q) begin
        if (cnt_q[c] == 5'sd0 || diff == 6'sd0) begin
          if (qm[8]) begin
            sym_d[c] = {2'b01, qm[7:0]};
            nxt      = cnt6 + diff;
          end else begin
            sym_d[c] = {2'b10, ~qm[7:0]};
            nxt      = cnt6 - diff;
          end
        end else if ((!cnt_q[c][4] && diff > 6'sd0) || (cnt_q[c][4] && diff < 6'sd0)) begin
          sym_d[c] = {1'b1, qm[8], ~qm[7:0]};
          nxt      = cnt6 + (qm[8] ? 6'sd2 : 6'sd0) - diff;
        end else begin
          sym_d[c] = {1'b0, qm[8], qm[7:0]};
          nxt      = cnt6 - (qm[8] ? 6'sd0 : 6'sd2) + diff;
        end
      end
      cnt_d[c] = nxt[4:0];
    end
  end

  // Output symbols and disparity counters
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      for (int c = 0; c < 3; c++) begin
        sym_q[c] <= CTRL_00;
        cnt_q[c] <= 5'sd0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        sym_q[c] <= sym_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign tmds_ch0 = sym_q[0];
  assign tmds_ch1 = sym_q[1];
  assign tmds_ch2 = sym_q[2];

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Directed and model-compared bench for dvi_tmds_encoder (BPC=8 and BPC=5).
module tb_dvi_tmds_encoder;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       de = 1'b0, hs = 1'b0, vs = 1'b0;
  logic [7:0] r8 = '0, g8 = '0, b8 = '0;
  logic [4:0] r5 = '0, g5 = '0, b5 = '0;
  logic [9:0] o8_0, o8_1, o8_2;
  logic [9:0] o5_0, o5_1, o5_2;

  int n_chk  = 0;
  int n_pass = 0;
  int mcnt [3];

  always #5 clk = ~clk;

  dvi_tmds_encoder #(.BPC(8)) dut8 (
    .clk_pix(clk), .rst_pix(rst), .de(de), .hsync(hs), .vsync(vs),
    .r(r8), .g(g8), .b(b8),
    .tmds_ch0(o8_0), .tmds_ch1(o8_1), .tmds_ch2(o8_2)
  );

  dvi_tmds_encoder #(.BPC(5)) dut5 (
    .clk_pix(clk), .rst_pix(rst), .de(de), .hsync(hs), .vsync(vs),
    .r(r5), .g(g5), .b(b5),
    .tmds_ch0(o5_0), .tmds_ch1(o5_1), .tmds_ch2(o5_2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %b expected %b", tag, got[9:0], exp[9:0]);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set8(input logic [7:0] v);
    r8 = v; g8 = v; b8 = v;
  endtask

  task automatic check_all8(input string tag, input logic [9:0] exp);
    check({tag, "_ch0"}, {22'd0, o8_0}, {22'd0, exp});
    check({tag, "_ch1"}, {22'd0, o8_1}, {22'd0, exp});
    check({tag, "_ch2"}, {22'd0, o8_2}, {22'd0, exp});
  endtask

  // Reference encoder: one symbol per call, updating mcnt[ch].
  function automatic logic [9:0] model_sym(input int ch, input logic den,
                                           input logic [1:0] ctl, input logic [7:0] d);
    int         n1, n1q, disp;
    logic       xnr;
    logic [8:0] qm;
    logic [9:0] s;
    if (!den) begin
      mcnt[ch] = 0;
      case (ctl)
        2'b00: s = C00;
        2'b01: s = C01;
        2'b10: s = C10;
        default: s = C11;
      endcase
      return s;
    end
    n1 = 0;
    for (int i = 0; i < 8; i++) if (d[i]) n1++;
    xnr = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xnr ? !(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xnr;
    n1q = 0;
    for (int i = 0; i < 8; i++) if (qm[i]) n1q++;
    disp = n1q - (8 - n1q);
    if (mcnt[ch] == 0 || disp == 0) begin
      if (qm[8]) begin s = {2'b01, qm[7:0]};  mcnt[ch] += disp; end
      else       begin s = {2'b10, ~qm[7:0]}; mcnt[ch] -= disp; end
    end else if ((mcnt[ch] > 0 && disp > 0) || (mcnt[ch] < 0 && disp < 0)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      mcnt[ch] += (qm[8] ? 2 : 0) - disp;
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      mcnt[ch] += (qm[8] ? 0 : -2) + disp;
    end
    return s;
  endfunction

  function automatic logic [7:0] pick_byte();
    int sel;
    sel = $urandom_range(0, 5);
    if (sel == 0) return 8'h00;
    if (sel == 1) return 8'hFF;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    logic [9:0] e_prev [3];
    logic [9:0] e_cur  [3];
    logic [9:0] outs   [3];
    logic       prev_de;
    int         dsum   [3];

    // Reset state while reset is held
    step();
    check_all8("rst8", C00);
    check("rst5_ch0", {22'd0, o5_0}, {22'd0, C00});
    rst = 1'b0;

    // Blanking control codes on ch0, fixed 00 on ch1/ch2
    de = 1'b0; hs = 1'b1; vs = 1'b0;
    step(); step();
    check("ctl01_ch0", {22'd0, o8_0}, {22'd0, C01});
    check("ctl01_ch1", {22'd0, o8_1}, {22'd0, C00});
    check("ctl01_ch2", {22'd0, o8_2}, {22'd0, C00});
    vs = 1'b1;
    step(); step();
    check("ctl11_ch0", {22'd0, o8_0}, {22'd0, C11});
    hs = 1'b0;
    step(); step();
    check("ctl10_ch0", {22'd0, o8_0}, {22'd0, C10});
    vs = 1'b0;

    // Three pixels of 0x00: disparity -8, +2, -6
    do_reset();
    de = 1'b1; set8(8'h00);
    step(); step();
    check_all8("zero_p0", 10'b0100000000);
    step();
    check_all8("zero_p1", 10'b1111111111);
    step();
    check_all8("zero_p2", 10'b0100000000);

    // 0xFF, one blank cycle, then 0x00 with a cleared counter
    do_reset();
    de = 1'b1; set8(8'hFF);
    step();
    de = 1'b0;
    step();
    check_all8("ff", 10'b1000000000);
    de = 1'b1; set8(8'h00);
    step();
    check_all8("ff_blank", C00);
    step();
    check_all8("after_blank", 10'b0100000000);

    // BPC=5 expansion: 11111->0xFF, 00000->0x00, 10000->0x84
    do_reset();
    r5 = 5'b11111; g5 = 5'b00000; b5 = 5'b10000; de = 1'b1;
    step(); step();
    check("bpc5_ch2", {22'd0, o5_2}, {22'd0, 10'b1000000000});
    check("bpc5_ch1", {22'd0, o5_1}, {22'd0, 10'b0100000000});
    check("bpc5_ch0", {22'd0, o5_0}, {22'd0, 10'b0101111100});

    // Asynchronous reset in the middle of a 0x00 burst
    do_reset();
    de = 1'b1; set8(8'h00);
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    check_all8("async_rst", C00);
    step();
    rst = 1'b0;
    step();
    check_all8("post_rst_c0", C00);
    step();
    check_all8("post_rst_d0", 10'b0100000000);

    // Random traffic against the reference encoder
    do_reset();
    for (int c = 0; c < 3; c++) begin
      mcnt[c] = 0; e_prev[c] = C00; dsum[c] = 0;
    end
    prev_de = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      de = ($urandom_range(0, 9) != 0);
      hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
      r8 = pick_byte(); g8 = pick_byte(); b8 = pick_byte();
      e_cur[0] = model_sym(0, de, {vs, hs}, b8);
      e_cur[1] = model_sym(1, de, 2'b00, g8);
      e_cur[2] = model_sym(2, de, 2'b00, r8);
      step();
      outs[0] = o8_0; outs[1] = o8_1; outs[2] = o8_2;
      check("rnd_ch0", {22'd0, outs[0]}, {22'd0, e_prev[0]});
      check("rnd_ch1", {22'd0, outs[1]}, {22'd0, e_prev[1]});
      check("rnd_ch2", {22'd0, outs[2]}, {22'd0, e_prev[2]});
      for (int c = 0; c < 3; c++) begin
        if (prev_de) begin
          dsum[c] += 2 * $countones(outs[c]) - 10;
          check("rnd_disp", {31'd0, (dsum[c] <= 10 && dsum[c] >= -10)}, 32'd1);
        end else begin
          dsum[c] = 0;
        end
        e_prev[c] = e_cur[c];
      end
      prev_de = de;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
